// File: rtl/shift_sequencer_ctrl_if.sv
// Handshake/data bundle between the ALU pipeline and the iterative shift unit.
//   master : pipeline side  - drives start, flush, op, data_in, shamt
//   slave  : shifter side   - drives ready, busy, done, result
interface shift_sequencer_ctrl_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               start;
  logic               flush;
  logic [1:0]         op;
  logic [DATA_W-1:0]  data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               ready;
  logic               busy;
  logic               done;
  logic [DATA_W-1:0]  result;

  modport master (
    output start, flush, op, data_in, shamt,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, flush, op, data_in, shamt,
    output ready, busy, done, result
  );
endinterface

// File: rtl/shift_sequencer_ctrl.sv
// Iterative shift unit: applies one fixed power-of-two shift step per cycle
// (distance 2^step, step = 0..SHAMT_W-1), gated by the matching shamt bit.
// Supports SLL, SRL, SRA and ROL with a start/ready/busy/done handshake.
//   clock : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : slave side of shift_sequencer_ctrl_if (start/flush/op/data_in/shamt
//           in; ready/busy/done/result out, all registered)
module shift_sequencer_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  shift_sequencer_ctrl_if.slave  bus
);

  localparam int unsigned STEP_W    = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam int unsigned LAST_STEP = SHAMT_W - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROL} op_e;

  state_e             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  op_e                op_q, op_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;

  logic               accept_c;
  logic [DATA_W-1:0]  shifted_c;

  // One fixed-distance step, selected by the current step index.
  always_comb begin
    shifted_c = result_q;
    for (int k = 0; k < int'(SHAMT_W); k++) begin
      if (step_q == STEP_W'(k)) begin
        case (op_q)
          OP_SLL:  shifted_c = result_q << (2**k);
          OP_SRL:  shifted_c = result_q >> (2**k);
          OP_SRA:  shifted_c = DATA_W'($signed(result_q) >>> (2**k));
          default: shifted_c = (result_q << (2**k)) | (result_q >> (DATA_W - 2**k));
        endcase
      end
    end
  end

  assign accept_c = bus.start & ready_q & ~bus.flush;

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    op_d     = op_q;
    shamt_d  = shamt_q;
    result_d = result_q;

    case (state_q)
      SHIFT: begin
        if (shamt_q[step_q]) begin
          result_d = shifted_c;
        end
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(LAST_STEP)) begin
          state_d = DONE;
          step_d  = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Accept from IDLE or DONE (back-to-back) reloads operands.
    if (accept_c) begin
      state_d  = SHIFT;
      step_d   = '0;
      op_d     = op_e'(bus.op);
      shamt_d  = bus.shamt;
      result_d = bus.data_in;
    end

    // Flush wins over everything; result keeps its partial value.
    if (bus.flush) begin
      state_d  = IDLE;
      step_d   = '0;
      result_d = result_q;
    end

    // Status outputs are registered, so they are decoded from the next state.
    done_d  = (state_d == DONE);
    busy_d  = (state_d == SHIFT);
    ready_d = (state_d != SHIFT);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= '0;
      op_q     <= OP_SLL;
      shamt_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      op_q     <= op_d;
      shamt_q  <= shamt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_shift_sequencer_ctrl.sv
// Directed testbench for shift_sequencer_ctrl: shift ops, latency, back-to-back,
// flush and mid-operation reset.
module tb_shift_sequencer_ctrl;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  shift_sequencer_ctrl_if #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) bus ();

  shift_sequencer_ctrl #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge and settle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present an op for one accept edge, then scramble the operands.
  task automatic launch(input logic [1:0] op, input logic [31:0] data, input logic [4:0] sh);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.data_in = data;
    bus.shamt   = sh;
    tick();
    bus.start   = 1'b0;
    bus.op      = 2'(~op);
    bus.data_in = 32'hDEAD_BEEF;
    bus.shamt   = 5'(~sh);
  endtask

  // Edges until done (bounded), plus busy cycles seen since the accept edge.
  task automatic wait_done(output int n, output int busy_cnt);
    n        = 0;
    busy_cnt = bus.busy ? 1 : 0;
    while (n < 12) begin
      tick();
      n++;
      if (bus.done) break;
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: ready=%b busy=%b done=%b result=%h required 1 0 0 00000000",
               bus.ready, bus.busy, bus.done, bus.result);
    end
  endtask

  task automatic test_shift_ops();
    logic [1:0]  ops  [7] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b11, 2'b00, 2'b11};
    logic [31:0] din  [7] = '{32'h0000_0001, 32'h8000_0F00, 32'h8000_0F00, 32'h1234_5678,
                              32'h1234_5678, 32'hF0F0_F0F0, 32'h8000_0001};
    logic [4:0]  shs  [7] = '{5'd31, 5'd8, 5'd8, 5'd4, 5'd0, 5'd3, 5'd31};
    logic [31:0] exps [7] = '{32'h8000_0000, 32'hFF80_000F, 32'h0080_000F, 32'h2345_6781,
                              32'h1234_5678, 32'h8787_8780, 32'hC000_0000};
    int n;
    int bc;
    for (int i = 0; i < 7; i++) begin
      launch(ops[i], din[i], shs[i]);
      wait_done(n, bc);
      checks++;
      if (n !== 5 || bc !== 5) begin
        errors++;
        $display("FAIL op%0d_latency: done_after=%0d busy_cycles=%0d required 5 5", i, n, bc);
      end
      checks++;
      if (bus.result !== exps[i] || bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL op%0d_result: result=%h ready=%b busy=%b required %h 1 0",
                 i, bus.result, bus.ready, bus.busy, exps[i]);
      end
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.result !== exps[i]) begin
        errors++;
        $display("FAIL op%0d_done_pulse: done=%b result=%h required 0 %h", i, bus.done, bus.result, exps[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int bc;
    // First op SLL 1 by 1; keep start high with a different op during SHIFT.
    bus.start   = 1'b1;
    bus.op      = 2'b00;
    bus.data_in = 32'h0000_0001;
    bus.shamt   = 5'd1;
    tick();
    bus.op      = 2'b01;
    bus.data_in = 32'hF000_0000;
    bus.shamt   = 5'd4;
    wait_done(n, bc);
    checks++;
    if (n !== 5 || bus.result !== 32'h0000_0002 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: done_after=%0d result=%h ready=%b required 5 00000002 1", n, bus.result, bus.ready);
    end
    wait_done(n, bc);
    checks++;
    if (n !== 6 || bus.result !== 32'h0F00_0000) begin
      errors++;
      $display("FAIL b2b_second: done_after=%0d result=%h required 6 0f000000", n, bus.result);
    end
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: done=%b busy=%b ready=%b required 0 0 1", bus.done, bus.busy, bus.ready);
    end
  endtask

  task automatic test_flush();
    int seen_done;
    launch(2'b00, 32'h0000_0001, 5'd31);
    tick();
    tick();
    // Third SHIFT cycle: two steps applied so far (1 -> 2 -> 8).
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.result !== 32'h0000_0008) begin
      errors++;
      $display("FAIL flush_abort: busy=%b ready=%b done=%b result=%h required 0 1 0 00000008",
               bus.busy, bus.ready, bus.done, bus.result);
    end
    seen_done = 0;
    repeat (7) begin
      tick();
      if (bus.done) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("FAIL flush_no_done: done_pulses=%0d required 0", seen_done);
    end
    // Flush and start together: no accept.
    bus.flush   = 1'b1;
    bus.start   = 1'b1;
    bus.op      = 2'b00;
    bus.data_in = 32'h0000_00FF;
    bus.shamt   = 5'd0;
    tick();
    bus.flush = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b1 || bus.result !== 32'h0000_0008) begin
      errors++;
      $display("FAIL flush_beats_start: busy=%b ready=%b result=%h required 0 1 00000008",
               bus.busy, bus.ready, bus.result);
    end
    seen_done = 0;
    repeat (7) begin
      tick();
      if (bus.done) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("FAIL flush_start_no_done: done_pulses=%0d required 0", seen_done);
    end
  endtask

  task automatic test_reset_mid_op();
    int n;
    int bc;
    launch(2'b11, 32'h1234_5678, 5'd4);
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: ready=%b busy=%b done=%b result=%h required 1 0 0 00000000",
               bus.ready, bus.busy, bus.done, bus.result);
    end
    tick();
    reset = 1'b0;
    tick();
    launch(2'b10, 32'h8000_0000, 5'd31);
    wait_done(n, bc);
    checks++;
    if (n !== 5 || bus.result !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_recover: done_after=%0d result=%h required 5 ffffffff", n, bus.result);
    end
    tick();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.op      = 2'b00;
    bus.data_in = '0;
    bus.shamt   = '0;
    #12;
    test_reset();
    @(negedge clock);
    reset = 1'b0;
    tick();
    test_shift_ops();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
